// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage instruction/stall bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             flush;
  logic             stall_out;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_in, instr_valid, flush,
    input  stall_out, stall_count
  );

  modport slave (
    input  instr_in, instr_valid, flush,
    output stall_out, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode RAW hazard scoreboard with stall counter; HAZARD_FWD_EN limits stalls to load-use
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int WIN   = 2,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  hazard_scoreboard_if.slave bus
);
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       reads_rs, reads_rt, writes, is_load;
  logic [4:0] dest;
  logic       unused_funct;

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_load;
  logic [4:0]       e_dest [DEPTH];
  logic [CNT_W-1:0] count;

  logic hit_rs, hit_rt, stall, accept;

  assign opcode       = bus.instr_in[31:26];
  assign rs           = bus.instr_in[25:21];
  assign rt           = bus.instr_in[20:16];
  assign rd           = bus.instr_in[15:11];
  assign unused_funct = ^bus.instr_in[10:0];

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    is_load  = 1'b0;
    dest     = 5'd0;
    casez (opcode)
      6'b001???: begin reads_rs = 1'b1; writes = 1'b1; dest = rt; end
      6'b100???: begin reads_rs = 1'b1; writes = 1'b1; dest = rt; is_load = 1'b1; end
      6'b101???: begin reads_rs = 1'b1; reads_rt = 1'b1; end
      6'b00010?: begin reads_rs = 1'b1; reads_rt = 1'b1; end
      6'b00011?: reads_rs = 1'b1;
      6'b000001: reads_rs = 1'b1;
      6'b000000: begin reads_rs = 1'b1; reads_rt = 1'b1; writes = 1'b1; dest = rd; end
      6'b000011: begin writes = 1'b1; dest = 5'd31; end
      default: ;
    endcase
  end

`ifdef HAZARD_FWD_EN
  // EX/MEM forwarding covers ALU results; only a load one slot ahead can't be bypassed
  always_comb begin
    hit_rs = (rs != 5'd0) && e_valid[0] && e_load[0] && (e_dest[0] == rs);
    hit_rt = (rt != 5'd0) && e_valid[0] && e_load[0] && (e_dest[0] == rt);
  end
`else
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      if (e_valid[i] && (e_dest[i] == rs)) hit_rs = 1'b1;
      if (e_valid[i] && (e_dest[i] == rt)) hit_rt = 1'b1;
    end
    if (rs == 5'd0) hit_rs = 1'b0;
    if (rt == 5'd0) hit_rt = 1'b0;
  end
`endif

  assign stall  = bus.instr_valid & ~bus.flush & ((reads_rs & hit_rs) | (reads_rt & hit_rt));
  assign accept = bus.instr_valid & ~bus.flush & ~stall;

  assign bus.stall_out   = stall;
  assign bus.stall_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid <= '0;
      e_load  <= '0;
      for (int i = 0; i < DEPTH; i++) e_dest[i] <= 5'd0;
      count   <= '0;
    end else begin
      // a zero destination goes in as a bubble so $0 can never be matched
      e_valid <= bus.flush ? '0 : {e_valid[DEPTH-2:0], accept & writes & (dest != 5'd0)};
      e_load  <= {e_load[DEPTH-2:0], accept & is_load};
      e_dest[0] <= dest;
      for (int i = 1; i < DEPTH; i++) e_dest[i] <= e_dest[i-1];
      if (stall && (count != {CNT_W{1'b1}})) count <= count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - queue-scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int CNT_W = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] ADDI_1   = 32'h20010005;
  localparam logic [31:0] ADD_2_11 = 32'h00211020;
  localparam logic [31:0] ADDI_0   = 32'h20000001;
  localparam logic [31:0] ADD_2_00 = 32'h00001020;
  localparam logic [31:0] JAL      = 32'h0C000000;
  localparam logic [31:0] JR_31    = 32'h03E00008;
  localparam logic [31:0] LW_3     = 32'h8C230000;
  localparam logic [31:0] ADD_4_30 = 32'h00602020;
  localparam logic [31:0] ADDI_3   = 32'h20030000;
  localparam logic [31:0] LW_1     = 32'h8C010000;

  typedef struct {
    int    n;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.DEPTH(3), .WIN(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   run_len = 0;
  exp_t exp_q[$];

  // each queued item is closed by the first cycle that does not stall
  always @(negedge clk) begin
    if (bus.stall_out) begin
      run_len++;
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (run_len != e.n) begin
        errors++;
        $display("FAIL %s: got %0d stall cycles, expected %0d", e.name, run_len, e.n);
      end
      run_len = 0;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic issue(input string name, input logic [31:0] ins, input logic v,
                       input logic f, input int exp_n);
    exp_t e;
    e.n = exp_n;
    e.name = name;
    exp_q.push_back(e);
    bus.instr_in    = ins;
    bus.instr_valid = v;
    bus.flush       = f;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!bus.stall_out) break;
      if (n >= 10) begin
        checks++;
        errors++;
        $display("FAIL %s: stall did not clear within 10 cycles, expected %0d", name, exp_n);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.instr_in    = 32'd0;
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall_out", int'(bus.stall_out), 0);
    chk("reset_stall_count", int'(bus.stall_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue("addi_1", ADDI_1, 1'b1, 1'b0, 0);
    issue("alu_raw_add", ADD_2_11, 1'b1, 1'b0, FWD ? 0 : 2);
    chk("count_after_alu_raw", int'(bus.stall_count), FWD ? 0 : 2);

    issue("addi_r0", ADDI_0, 1'b1, 1'b0, 0);
    issue("add_reads_r0", ADD_2_00, 1'b1, 1'b0, 0);
    issue("jal", JAL, 1'b1, 1'b0, 0);
    issue("jr_31", JR_31, 1'b1, 1'b0, FWD ? 0 : 2);
    chk("count_after_jr", int'(bus.stall_count), FWD ? 0 : 4);

    issue("lw_3", LW_3, 1'b1, 1'b0, 0);
    issue("load_use_add", ADD_4_30, 1'b1, 1'b0, FWD ? 1 : 2);
    chk("count_after_load_use", int'(bus.stall_count), FWD ? 1 : 6);
    issue("addi_3", ADDI_3, 1'b1, 1'b0, 0);
    issue("alu_use_add", ADD_4_30, 1'b1, 1'b0, FWD ? 0 : 2);
    chk("count_after_alu_use", int'(bus.stall_count), FWD ? 1 : 8);

    issue("flush_producer", ADDI_1, 1'b1, 1'b0, 0);
    issue("flush_cycle", ADD_2_11, 1'b1, 1'b1, 0);
    issue("after_flush_add", ADD_2_11, 1'b1, 1'b0, 0);
    chk("count_after_flush", int'(bus.stall_count), FWD ? 1 : 8);

    issue("invalid_producer", ADDI_1, 1'b1, 1'b0, 0);
    issue("invalid_consumer", ADD_2_11, 1'b0, 1'b0, 0);
    chk("count_after_invalid", int'(bus.stall_count), FWD ? 1 : 8);
    issue("late_consumer", ADD_2_11, 1'b1, 1'b0, FWD ? 0 : 1);
    chk("count_after_late", int'(bus.stall_count), FWD ? 1 : 9);

    for (int k = 0; k < 15; k++) begin
      issue("sat_lw", LW_1, 1'b1, 1'b0, 0);
      issue("sat_add", ADD_2_11, 1'b1, 1'b0, FWD ? 1 : 2);
    end
    chk("count_saturated", int'(bus.stall_count), 15);

    issue("sat_invalid_lw", LW_1, 1'b1, 1'b0, 0);
    issue("sat_invalid_add", ADD_2_11, 1'b0, 1'b0, 0);
    chk("count_hold_invalid", int'(bus.stall_count), 15);

    issue("reset_producer", LW_1, 1'b1, 1'b0, 0);
    reset = 1'b1;
    issue("consumer_in_reset", ADD_2_11, 1'b1, 1'b0, 0);
    chk("reset_mid_count", int'(bus.stall_count), 0);
    bus.instr_in    = ADD_2_11;
    bus.instr_valid = 1'b1;
    #1;
    chk("reset_mid_stall_out", int'(bus.stall_out), 0);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue("first_after_reset", ADD_2_11, 1'b1, 1'b0, 0);
    chk("count_after_reset", int'(bus.stall_count), 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
